// File: rtl/fc_load_pkg.sv
// Shared types and parameter helpers for the FC weight/bias load sequencer.
package fc_load_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READY,
      ST_RUN
   } state_t;

   typedef enum logic {
      PH_WEIGHT,
      PH_BIAS
   } phase_t;

   // Number of host words in one complete load (all weights followed by all biases).
   function automatic int calc_total(input int ifm_depth, input int n_wm);
      return n_wm * (ifm_depth + 1);
   endfunction

   function automatic int calc_bias_base(input int base_addr, input int ifm_depth, input int n_wm);
      return base_addr + n_wm * ifm_depth;
   endfunction

endpackage

// File: rtl/fc_weight_load_ctrl_if.sv
// Host write stream, FC-top write port and start/done handshake of the load sequencer.
interface fc_weight_load_ctrl_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 15,
   parameter int NUMBER_OF_WM = 10
) ();
   logic                    host_valid;
   logic                    host_ready;
   logic [DATA_WIDTH-1:0]   host_data;
   logic [ADDRESS_BITS-1:0] host_address;
   logic [DATA_WIDTH-1:0]   riscv_data;
   logic [ADDRESS_BITS-1:0] riscv_address;
   logic [NUMBER_OF_WM-1:0] wm_enable_write;
   logic                    bm_enable_write;
   logic                    start_from_previous;
   logic                    start_to_cu;
   logic                    output_ready;
   logic                    weights_loaded;
   logic                    load_error;

   modport master (
      output host_valid, host_data, host_address, start_from_previous, output_ready,
      input  host_ready, riscv_data, riscv_address, wm_enable_write, bm_enable_write,
             start_to_cu, weights_loaded, load_error
   );

   modport slave (
      input  host_valid, host_data, host_address, start_from_previous, output_ready,
      output host_ready, riscv_data, riscv_address, wm_enable_write, bm_enable_write,
             start_to_cu, weights_loaded, load_error
   );
endinterface

// File: rtl/fc_load_ptr.sv
// Expected-address tracker: flat host address plus memory/word indices and phase,
// stepped by increments only so no divider or multiplier is needed.
module fc_load_ptr
   import fc_load_pkg::*;
#(
   parameter int ADDRESS_BITS = 15,
   parameter int IFM_DEPTH    = 80,
   parameter int NUMBER_OF_WM = 10,
   parameter int BASE_ADDR    = 0,
   localparam int LOCAL_AW    = $clog2(IFM_DEPTH),
   localparam int MEM_W       = (NUMBER_OF_WM > 1) ? $clog2(NUMBER_OF_WM) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_advance,
   input  logic                    i_clear,
   output logic [ADDRESS_BITS-1:0] o_exp_addr,
   output logic [MEM_W-1:0]        o_mem_idx,
   output logic [LOCAL_AW-1:0]     o_word_idx,
   output phase_t                  o_phase,
   output logic                    o_last
);
   localparam logic [ADDRESS_BITS-1:0] FIRST_ADDR = ADDRESS_BITS'(BASE_ADDR);
   localparam logic [ADDRESS_BITS-1:0] LAST_ADDR  =
      ADDRESS_BITS'(BASE_ADDR + calc_total(IFM_DEPTH, NUMBER_OF_WM) - 1);

   logic [ADDRESS_BITS-1:0] r_exp_addr;
   logic [MEM_W-1:0]        r_mem_idx;
   logic [LOCAL_AW-1:0]     r_word_idx;
   phase_t                  r_phase;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_exp_addr <= FIRST_ADDR;
         r_mem_idx  <= '0;
         r_word_idx <= '0;
         r_phase    <= PH_WEIGHT;
      end else if (i_advance) begin
         r_exp_addr <= r_exp_addr + ADDRESS_BITS'(1);
         if (r_phase == PH_BIAS) begin
            r_mem_idx <= r_mem_idx + MEM_W'(1);
         end else if (r_word_idx == LOCAL_AW'(IFM_DEPTH - 1)) begin
            r_word_idx <= '0;
            // last weight of the last memory hands over to the bias words
            if (r_mem_idx == MEM_W'(NUMBER_OF_WM - 1)) begin
               r_mem_idx <= '0;
               r_phase   <= PH_BIAS;
            end else begin
               r_mem_idx <= r_mem_idx + MEM_W'(1);
            end
         end else begin
            r_word_idx <= r_word_idx + LOCAL_AW'(1);
         end
      end
   end

   assign o_exp_addr = r_exp_addr;
   assign o_mem_idx  = r_mem_idx;
   assign o_word_idx = r_word_idx;
   assign o_phase    = r_phase;
   assign o_last     = (r_exp_addr == LAST_ADDR);

endmodule

// File: rtl/fc_weight_load_ctrl.sv
// Ordered weight/bias loader for one FC layer; gates the layer start until loading is done
// and blocks host writes while the layer computes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | nothing loaded, waiting for the write to BASE_ADDR
// ST_LOAD  | ordered load in progress
// ST_READY | all words loaded, waiting for a start (or a reload at BASE_ADDR)
// ST_RUN   | layer computing, host writes held off until output_ready
module fc_weight_load_ctrl
   import fc_load_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 15,
   parameter int IFM_DEPTH    = 80,
   parameter int NUMBER_OF_WM = 10,
   parameter int BASE_ADDR    = 0,
   localparam int LOCAL_AW    = $clog2(IFM_DEPTH),
   localparam int MEM_W       = (NUMBER_OF_WM > 1) ? $clog2(NUMBER_OF_WM) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   fc_weight_load_ctrl_if.slave  bus
);
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_host_ready;
   logic                    w_accept;
   logic                    w_hit;
   logic                    w_err;
   logic                    w_start_req;
   logic                    w_fire;
   logic                    w_last;
   logic [ADDRESS_BITS-1:0] w_exp_addr;
   logic [MEM_W-1:0]        w_mem_idx;
   logic [LOCAL_AW-1:0]     w_word_idx;
   phase_t                  w_phase;

   logic [NUMBER_OF_WM-1:0] r_wm_en;
   logic                    r_bm_en;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [ADDRESS_BITS-1:0] r_addr;
   logic                    r_start;
   logic                    r_pending;
   logic                    r_err;

   fc_load_ptr #(
      .ADDRESS_BITS (ADDRESS_BITS),
      .IFM_DEPTH    (IFM_DEPTH),
      .NUMBER_OF_WM (NUMBER_OF_WM),
      .BASE_ADDR    (BASE_ADDR)
   ) u_ptr (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_advance  (w_hit),
      .i_clear    (w_hit & w_last),
      .o_exp_addr (w_exp_addr),
      .o_mem_idx  (w_mem_idx),
      .o_word_idx (w_word_idx),
      .o_phase    (w_phase),
      .o_last     (w_last)
   );

   assign w_host_ready = (r_state != ST_RUN);
   assign w_accept     = bus.host_valid & w_host_ready;
   assign w_hit        = w_accept && (bus.host_address == w_exp_addr);
   assign w_err        = w_accept && !w_hit;
   assign w_start_req  = r_pending | bus.start_from_previous;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      case (r_state)
         ST_IDLE, ST_LOAD: begin
            if (w_hit) begin
               if (w_last) begin
                  // a start waiting for the load fires together with weights_loaded
                  if (w_start_req) begin
                     w_fire      = 1'b1;
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_READY;
                  end
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end
         end
         ST_READY: begin
            if (w_start_req) begin
               w_fire      = 1'b1;
               w_state_nxt = ST_RUN;
            end else if (w_hit) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (bus.output_ready) w_state_nxt = ST_READY;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pending <= 1'b0;
      end else if (w_fire) begin
         r_pending <= 1'b0;
      end else if (bus.start_from_previous &&
                   ((r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                    ((r_state == ST_RUN) && bus.output_ready))) begin
         r_pending <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wm_en <= '0;
         r_bm_en <= 1'b0;
         r_data  <= '0;
         r_addr  <= '0;
         r_start <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_wm_en <= '0;
         r_bm_en <= 1'b0;
         r_start <= w_fire;
         if (w_hit) begin
            r_data <= bus.host_data;
            if (w_phase == PH_WEIGHT) begin
               r_wm_en <= NUMBER_OF_WM'(1) << w_mem_idx;
               r_addr  <= ADDRESS_BITS'(w_word_idx);
            end else begin
               r_bm_en <= 1'b1;
               r_addr  <= ADDRESS_BITS'(w_mem_idx);
            end
         end
         if (w_err) r_err <= 1'b1;
      end
   end

   assign bus.host_ready      = w_host_ready;
   assign bus.riscv_data      = r_data;
   assign bus.riscv_address   = r_addr;
   assign bus.wm_enable_write = r_wm_en;
   assign bus.bm_enable_write = r_bm_en;
   assign bus.start_to_cu     = r_start;
   assign bus.weights_loaded  = (r_state == ST_READY) || (r_state == ST_RUN);
   assign bus.load_error      = r_err;

endmodule

// File: tb/tb_fc_weight_load_ctrl.sv
// Bench for fc_weight_load_ctrl: directed load scenarios plus random traffic, all
// checked against a flat-index behavioural model of the load/start rules.
module tb_fc_weight_load_ctrl;
   localparam int DW    = 32;
   localparam int AB    = 15;
   localparam int IFM   = 80;
   localparam int NWM   = 10;
   localparam int BASE  = 0;
   localparam int NW    = NWM * IFM;
   localparam int TOTAL = NWM * (IFM + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fc_weight_load_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .NUMBER_OF_WM(NWM)) bus ();

   fc_weight_load_ctrl #(
      .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .IFM_DEPTH(IFM), .NUMBER_OF_WM(NWM), .BASE_ADDR(BASE)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_start  = 0;

   // model state: next expected absolute address and coarse layer status
   int              m_next = BASE;
   bit              m_loaded = 0, m_run = 0, m_pend = 0, m_err = 0;
   logic [NWM-1:0]  e_wm;
   bit              e_bm, e_start;
   logic [DW-1:0]   e_data;
   int              e_addr;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit v, input int a, input logic [DW-1:0] d,
                             input bit s, input bit o, input bit r);
      bit acc, hit, req;
      int idx;
      e_wm = '0; e_bm = 0; e_start = 0;
      if (r) begin
         m_next = BASE; m_loaded = 0; m_run = 0; m_pend = 0; m_err = 0;
         return;
      end
      acc = v && !m_run;
      hit = acc && (a == m_next);
      req = m_pend || s;
      if (acc && !hit) m_err = 1;
      if (hit) begin
         idx = a - BASE;
         e_data = d;
         if (idx < NW) begin
            e_wm   = NWM'(1) << (idx / IFM);
            e_addr = idx % IFM;
         end else begin
            e_bm   = 1;
            e_addr = idx - NW;
         end
      end
      if (m_run) begin
         if (o) begin
            m_run = 0;
            if (s) m_pend = 1;
         end
      end else if (m_loaded) begin
         if (req) begin
            e_start = 1; m_pend = 0; m_run = 1;
         end
         if (hit) begin
            m_next++;
            if (!req) m_loaded = 0;
         end
      end else begin
         if (s) m_pend = 1;
         if (hit) begin
            m_next++;
            if (m_next == BASE + TOTAL) begin
               m_next = BASE; m_loaded = 1;
               if (m_pend) begin
                  e_start = 1; m_pend = 0; m_run = 1;
               end
            end
         end
      end
   endtask

   task automatic tick(input bit v, input int a, input logic [DW-1:0] d,
                       input bit s, input bit o, input bit r);
      bus.host_valid          = v;
      bus.host_address        = AB'(a);
      bus.host_data           = d;
      bus.start_from_previous = s;
      bus.output_ready        = o;
      rst                     = r;
      check_val("host_ready", 32'(bus.host_ready), 32'(!m_run));
      model_step(v, a, d, s, o, r);
      @(posedge clk);
      #1;
      check_val("wm_enable_write", 32'(bus.wm_enable_write), 32'(e_wm));
      check_val("bm_enable_write", 32'(bus.bm_enable_write), 32'(e_bm));
      check_val("start_to_cu", 32'(bus.start_to_cu), 32'(e_start));
      check_val("weights_loaded", 32'(bus.weights_loaded), 32'(m_loaded));
      check_val("load_error", 32'(bus.load_error), 32'(m_err));
      if (e_wm != '0 || e_bm) begin
         check_val("riscv_data", bus.riscv_data, e_data);
         check_val("riscv_address", 32'(bus.riscv_address), 32'(e_addr));
      end
      if (bus.start_to_cu) n_start++;
   endtask

   initial begin
      int a;
      bus.host_valid = 0; bus.host_address = '0; bus.host_data = '0;
      bus.start_from_previous = 0; bus.output_ready = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset host_ready", 32'(bus.host_ready), 32'd1);
      check_val("reset riscv_data", bus.riscv_data, 32'd0);
      check_val("reset riscv_address", 32'(bus.riscv_address), 32'd0);
      check_val("reset wm_enable_write", 32'(bus.wm_enable_write), 32'd0);
      check_val("reset weights_loaded", 32'(bus.weights_loaded), 32'd0);
      check_val("reset start_to_cu", 32'(bus.start_to_cu), 32'd0);
      rst = 0;

      // full back-to-back load with an early start at write 100
      n_start = 0;
      for (int i = 0; i < TOTAL; i++)
         tick(1, BASE + i, $urandom, (i == 99), 0, 0);
      check_val("early start pulse count", 32'(n_start), 32'd1);

      // host held off while the layer runs
      repeat (8) tick(1, BASE, $urandom, 0, 0, 0);
      tick(1, BASE, $urandom, 0, 1, 0);
      tick(1, BASE, $urandom, 0, 0, 0);
      check_val("reload clears weights_loaded", 32'(bus.weights_loaded), 32'd0);

      // out-of-order write is dropped, pointer holds
      for (int i = 1; i <= 3; i++) tick(1, BASE + i, $urandom, 0, 0, 0);
      tick(1, BASE + 5, $urandom, 0, 0, 0);
      tick(1, BASE + 4, $urandom, 0, 0, 0);
      for (int i = 5; i < 400; i++) tick(($urandom % 4) != 0 ? 1'b1 : 1'b0, m_next, $urandom, 0, 0, 0);
      while (m_next < BASE + 400) tick(1, m_next, $urandom, 0, 0, 0);

      // reset mid-load with a write in flight, then resume at the wrong address
      tick(1, BASE + 400, $urandom, 0, 0, 1);
      tick(1, BASE + 400, $urandom, 0, 0, 0);
      tick(1, BASE, $urandom, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 5000; i++) begin
         a = (($urandom % 16) == 0) ? int'($urandom % (TOTAL + 4)) : m_next;
         tick((($urandom % 10) < 7) ? 1'b1 : 1'b0, a, $urandom,
              (($urandom % 40) == 0) ? 1'b1 : 1'b0,
              (($urandom % 8) == 0) ? 1'b1 : 1'b0,
              (($urandom % 2000) == 0) ? 1'b1 : 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fc_weight_load_ctrl.md
# fc_weight_load_ctrl

Sequencer that loads weights and biases into an FC layer's weight memories (WM) and bias memory (BM) from the RISC-V host write stream, and gates the layer's start. It sits between the host bus and the FC top (`wm_enable_write`, `bm_enable_write`, `riscv_data`, `riscv_address` inputs). It also sits between the previous layer's `start_from_previous` and the FC control unit. It enforces strictly ordered loading, flags out-of-order writes, and blocks host writes while the layer computes.

## Interface
- DATA_WIDTH, 32, data word width
- ADDRESS_BITS, 15, host address width
- IFM_DEPTH, 80, words per weight memory
- NUMBER_OF_WM, 10, number of weight memories (= FC outputs)
- BASE_ADDR, 0, host address of WM0 word 0
- LOCAL_AW, $clog2(IFM_DEPTH), local memory address width
---
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- host_valid  in  1  host write request
- host_ready  out  1  write accepted when valid&ready
- host_data  in  DATA_WIDTH  write data
- host_address  in  ADDRESS_BITS  write address
- riscv_data  out  DATA_WIDTH  registered data to FC top
- riscv_address  out  ADDRESS_BITS  registered local address (zero-extended LOCAL_AW)
- wm_enable_write  out  NUMBER_OF_WM  one-hot WM write strobe
- bm_enable_write  out  1  BM write strobe
- start_from_previous  in  1  start pulse from previous layer
- start_to_cu  out  1  gated start pulse to FC control unit
- output_ready  in  1  FC layer done pulse
- weights_loaded  out  1  all WM+BM words written
- load_error  out  1  sticky: out-of-order write seen

## Operation
- Address map:
  - Weight word k of memory m is at BASE_ADDR + m*IFM_DEPTH + k.
  - Bias m is at BASE_ADDR + NUMBER_OF_WM*IFM_DEPTH + m.
  - TOTAL = NUMBER_OF_WM*(IFM_DEPTH+1).
- Expected pointer: flat counter `exp_addr`, plus `mem_idx`, `word_idx`, and phase (WEIGHT/BIAS). No division or multiplication in hardware.
  - In WEIGHT phase, `word_idx` wraps at IFM_DEPTH-1 and increments `mem_idx`.
  - After the last weight of memory NUMBER_OF_WM-1, the phase becomes BIAS and `mem_idx` returns to 0.
- FSM states:
  - IDLE: pointer at BASE_ADDR, host_ready=1. An accepted write at the expected address goes to LOAD.
  - LOAD: host_ready=1.
    - An accepted write with host_address==exp_addr is issued and the pointer advances.
    - On the TOTAL-th write, go to READY.
  - READY: weights_loaded=1, host_ready=1.
    - A pending or new start issues start_to_cu and moves to RUN.
    - An accepted write at BASE_ADDR restarts loading: weights_loaded clears, the write is issued, and the FSM goes to LOAD.
    - Any other write is an error.
  - RUN: host_ready=0, weights_loaded=1. output_ready returns the FSM to READY.
- Error handling:
  - In any state, an accepted write to an unexpected address is dropped (no strobe) and sets load_error. The pointer does not move.
  - load_error clears only on reset.
- Start handling:
  - start_from_previous in IDLE or LOAD sets `start_pending`.
  - start_to_cu is a 1-cycle pulse, only issued from READY, and clears `start_pending`.
  - start_from_previous in RUN is ignored.
- Issued write: in the cycle after acceptance, the selected strobe is 1 for exactly one cycle, with riscv_data and riscv_address held that cycle.
  - WEIGHT phase: wm_enable_write[mem_idx] and address word_idx.
  - BIAS phase: bm_enable_write and address mem_idx.

## Timing
- Reset: all outputs 0, except host_ready=1 (IDLE). FSM=IDLE, pointer=BASE_ADDR, start_pending=0.
- Write latency: 1 cycle from handshake to strobe. Throughput is 1 write per cycle, back-to-back.
- host_ready is a combinational function of state only, never of host_valid.
- weights_loaded rises the cycle after the final (TOTAL-th) handshake, together with that write's bm_enable_write strobe.
- start_to_cu:
  - A pending start fires the first cycle weights_loaded=1.
  - In READY, start_to_cu is registered one cycle after start_from_previous.
- A start and a restart write in the same READY cycle: the start wins. The FSM goes to RUN, host_ready=0 from the next cycle, and the write is still accepted in that cycle (ready was 1) and processed as a restart.
- output_ready and start_from_previous in the same RUN cycle: return to READY and latch the start as pending. It fires the next cycle.
- Reset mid-load: the pointer returns to BASE_ADDR, any in-flight strobe is suppressed, and the host must reload from the start.

## Structure
- Package `fc_load_pkg`:
  - State enum {IDLE, LOAD, READY, RUN}.
  - Phase enum {WEIGHT, BIAS}.
  - Function to compute TOTAL and BIAS_BASE from the parameters.
- One sub-module, `fc_load_ptr`: expected-address counter that owns exp_addr, mem_idx, word_idx and phase, with `advance`/`clear` inputs and a `last` output. The FSM and output registers stay in the top block.

## Test plan
- Full ordered load with IFM_DEPTH=80, NUMBER_OF_WM=10: 810 back-to-back writes from addr 0.
  - Address 79 gives wm_enable_write=10'b1 and riscv_address=79.
  - Address 80 gives bit 1 and riscv_address=0.
  - Address 800 gives bm_enable_write and riscv_address=0.
  - weights_loaded=1 after write 810; load_error=0.
- Out-of-order write: addr 5 written after addr 3 → no strobe, load_error=1, pointer stays at 4. Then write 4 → wm_enable_write[0] with riscv_address=4.
- Early start: start_from_previous during LOAD at write 100 → no start_to_cu until weights_loaded. start_to_cu pulses once in the cycle weights_loaded rises.
- RUN blocking: after start, host_valid held high → host_ready=0 and no strobes until output_ready. The write is accepted the cycle after output_ready.
- Reload: in READY, write to addr 0 → weights_loaded=0, wm_enable_write[0] strobe, state LOAD.
- Reset mid-load at write 400 → all outputs 0 (host_ready=1). The next write at addr 400 sets load_error; a write at addr 0 is accepted.
